// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave):
// request/grant for the address phase, rvalid for read data return.
interface load_store_unit_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wstrb;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [31:0]           mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory transaction per Load/Store strobe and stalls the core
// until it completes. Optional MISALIGN_TRAP_EN flags misaligned accesses instead of issuing them.
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Load,
   input  logic                  Store,
   input  logic [2:0]            fun3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           store_data,
   output logic                  stall,
   output logic [31:0]           load_data,
   output logic                  load_valid,
   output logic                  misalign,
   load_store_unit_if.master     mem
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

   state_e                state_q, state_d;
   logic                  is_load_q, is_load_d;
   logic [2:0]            fun3_q, fun3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           sdata_q, sdata_d;
   logic [31:0]           ldata_q, ldata_d;
   logic                  mis_q, mis_d;
   logic                  misaligned_in;
   logic [31:0]           rd_ext;
   logic [31:0]           rd_shift;
   logic [15:0]           rd_half;
   size_e                 st_size, ld_size;

   // Loads and stores decode funct3 differently: 100 is lbu for loads but a word store.
   function automatic size_e acc_size(input logic ld, input logic [2:0] f3);
      size_e sz;
      sz = SZ_WORD;
      if (ld) begin
         case (f3)
            3'b000, 3'b100: sz = SZ_BYTE;
            3'b001, 3'b101: sz = SZ_HALF;
            default:        sz = SZ_WORD;
         endcase
      end else begin
         case (f3)
            3'b000:  sz = SZ_BYTE;
            3'b001:  sz = SZ_HALF;
            default: sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

`ifdef MISALIGN_TRAP_EN
   size_e in_size;
   always_comb begin
      in_size       = acc_size(Load, fun3);
      misaligned_in = ((in_size == SZ_HALF) && addr[0]) ||
                      ((in_size == SZ_WORD) && (addr[1:0] != 2'b00));
   end
`else
   assign misaligned_in = 1'b0;
`endif

   assign st_size  = acc_size(1'b0, fun3_q);
   assign ld_size  = acc_size(1'b1, fun3_q);
   assign rd_shift = mem.mem_rdata >> {addr_q[1:0], 3'b000};
   assign rd_half  = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

   always_comb begin
      rd_ext = mem.mem_rdata;
      case (ld_size)
         SZ_BYTE: rd_ext = fun3_q[2] ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
         SZ_HALF: rd_ext = fun3_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         default: rd_ext = mem.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         is_load_q <= 1'b0;
         fun3_q    <= '0;
         addr_q    <= '0;
         sdata_q   <= '0;
         ldata_q   <= '0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_load_q <= is_load_d;
         fun3_q    <= fun3_d;
         addr_q    <= addr_d;
         sdata_q   <= sdata_d;
         ldata_q   <= ldata_d;
         mis_q     <= mis_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      is_load_d = is_load_q;
      fun3_d    = fun3_q;
      addr_d    = addr_q;
      sdata_d   = sdata_q;
      ldata_d   = ldata_q;
      mis_d     = mis_q;
      case (state_q)
         IDLE: begin
            if (Load || Store) begin
               is_load_d = Load;
               fun3_d    = fun3;
               addr_d    = addr;
               sdata_d   = store_data;
               mis_d     = misaligned_in;
               if (misaligned_in) begin
                  state_d = DONE;
                  if (Load) ldata_d = '0;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (mem.mem_gnt) begin
               if (!is_load_q) begin
                  state_d = DONE;
               end else if (mem.mem_rvalid) begin
                  ldata_d = rd_ext;
                  state_d = DONE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem.mem_rvalid) begin
               ldata_d = rd_ext;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall         = ((state_q == IDLE) && (Load || Store)) || (state_q == REQ) || (state_q == WAIT);
      load_data     = ldata_q;
      load_valid    = (state_q == DONE) && is_load_q;
      misalign      = (state_q == DONE) && mis_q;
      mem.mem_req   = (state_q == REQ);
      mem.mem_we    = (state_q == REQ) && !is_load_q;
      mem.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      mem.mem_wdata = sdata_q;
      mem.mem_wstrb = '0;
      case (st_size)
         SZ_BYTE: mem.mem_wdata = {4{sdata_q[7:0]}};
         SZ_HALF: mem.mem_wdata = {2{sdata_q[15:0]}};
         default: mem.mem_wdata = sdata_q;
      endcase
      if (mem.mem_we) begin
         case (st_size)
            SZ_BYTE: mem.mem_wstrb = 4'b0001 << addr_q[1:0];
            SZ_HALF: mem.mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: mem.mem_wstrb = 4'b1111;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset checks, a reset-mid-request sequence, then a
// vector table driving single transactions against a bench-side memory responder.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        Load, Store;
   logic [2:0]  fun3;
   logic [31:0] addr, store_data;
   logic        stall, load_valid, misalign;
   logic [31:0] load_data;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .Load       (Load),
      .Store      (Store),
      .fun3       (fun3),
      .addr       (addr),
      .store_data (store_data),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .misalign   (misalign),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int unsigned gdly;
      int unsigned rdly;
      logic        exp_req;
      logic        exp_we;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_ld;
      int unsigned exp_stall;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int unsigned stalls = 0, reqs = 0, waits = 0;
      bit          granted = 0, done = 0;
      logic [31:0] c_addr = '0, c_wdata = '0;
      logic [3:0]  c_wstrb = '0;
      logic        c_we = 1'b0;
      @(negedge clk);
      Load = v.ld; Store = v.st; fun3 = v.f3; addr = v.addr; store_data = v.sdata;
      #1;
      for (int c = 0; c < 60 && !done; c++) begin
         bus.mem_gnt = 1'b0;
         bus.mem_rvalid = 1'b0;
         if (!stall) begin
            done = 1;
         end else begin
            stalls++;
            if (bus.mem_req) begin
               reqs++;
               if (reqs == 1) begin
                  c_addr = bus.mem_addr; c_wdata = bus.mem_wdata;
                  c_wstrb = bus.mem_wstrb; c_we = bus.mem_we;
               end
               if (reqs > v.gdly) begin
                  bus.mem_gnt = 1'b1;
                  granted = 1;
                  if (v.ld && v.rdly == 0) begin
                     bus.mem_rvalid = 1'b1;
                     bus.mem_rdata = v.rdata;
                  end
               end
            end else if (granted) begin
               waits++;
               if (waits == v.rdly) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata = v.rdata;
               end
            end
            @(negedge clk);
            #1;
         end
      end
      check($sformatf("v%0d_completed", idx), {31'h0, done}, 32'h1);
      if (done) begin
         check($sformatf("v%0d_stall_cycles", idx), stalls, v.exp_stall);
         check($sformatf("v%0d_req_seen", idx), {31'h0, reqs != 0}, {31'h0, v.exp_req});
         if (v.exp_req && reqs != 0) begin
            check($sformatf("v%0d_mem_addr", idx), c_addr, v.exp_addr);
            check($sformatf("v%0d_mem_we", idx), {31'h0, c_we}, {31'h0, v.exp_we});
            check($sformatf("v%0d_mem_wstrb", idx), {28'h0, c_wstrb}, {28'h0, v.exp_wstrb});
            if (v.exp_we) check($sformatf("v%0d_mem_wdata", idx), c_wdata, v.exp_wdata);
         end
         check($sformatf("v%0d_load_valid_done", idx), {31'h0, load_valid}, {31'h0, v.ld});
         check($sformatf("v%0d_misalign_done", idx), {31'h0, misalign}, {31'h0, v.exp_mis});
         if (v.ld) check($sformatf("v%0d_load_data", idx), load_data, v.exp_ld);
         Load = 1'b0; Store = 1'b0;
         @(negedge clk);
         #1;
         check($sformatf("v%0d_load_valid_after", idx), {31'h0, load_valid}, 32'h0);
         check($sformatf("v%0d_misalign_after", idx), {31'h0, misalign}, 32'h0);
         check($sformatf("v%0d_stall_after", idx), {31'h0, stall}, 32'h0);
         if (v.ld) check($sformatf("v%0d_load_data_held", idx), load_data, v.exp_ld);
      end else begin
         Load = 1'b0; Store = 1'b0;
      end
   endtask

   initial begin
      //            ld    st    f3      addr          sdata         rdata       gd rd req   we    wstrb    exp_addr      exp_wdata     exp_ld    stall mis
      vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        2, 0, 1'b1, 1'b1, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0,        4, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0,        32'h0080_0000, 0, 0, 1'b1, 1'b0, 4'b0000, 32'h0000_2000, 32'h0,        32'hFFFF_FF80, 2, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_FFFF, 0, 3, 1'b1, 1'b0, 4'b0000, 32'h0000_2000, 32'h0,        32'h0000_8001, 5, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 3'b010, 32'h0000_4008, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1, 1'b1, 1'b0, 4'b0000, 32'h0000_4008, 32'h0,        32'h1234_5678, 4, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h0000_5002, 32'h1234_ABCD, 32'h0,        0, 0, 1'b1, 1'b1, 4'b1100, 32'h0000_5000, 32'hABCD_ABCD, 32'h0,        2, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_6000, 32'h0,        32'h0000_F00F, 0, 1, 1'b1, 1'b0, 4'b0000, 32'h0000_6000, 32'h0,        32'hFFFF_F00F, 3, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 3'b100, 32'h0000_7001, 32'h0,        32'h0000_FF00, 0, 0, 1'b1, 1'b0, 4'b0000, 32'h0000_7000, 32'h0,        32'h0000_00FF, 2, 1'b0};
`ifdef MISALIGN_TRAP_EN
      vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_3001, 32'hCAFE_F00D, 32'h0,        0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_A001, 32'h0,        32'h1122_8344, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 1'b1};
`else
      vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_3001, 32'hCAFE_F00D, 32'h0,        0, 0, 1'b1, 1'b1, 4'b1111, 32'h0000_3000, 32'hCAFE_F00D, 32'h0,        2, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_A001, 32'h0,        32'h1122_8344, 0, 0, 1'b1, 1'b0, 4'b0000, 32'h0000_A000, 32'h0,        32'hFFFF_8344, 2, 1'b0};
`endif
      vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h0000_8000, 32'h0000_005A, 32'h0,        0, 0, 1'b1, 1'b1, 4'b0001, 32'h0000_8000, 32'h5A5A_5A5A, 32'h0,        2, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 3'b110, 32'h0000_9000, 32'h0,        32'h89AB_CDEF, 0, 2, 1'b1, 1'b0, 4'b0000, 32'h0000_9000, 32'h0,        32'h89AB_CDEF, 4, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h0000_B002, 32'h0102_0304, 32'h0,        1, 0, 1'b1, 1'b1, 4'b1111, 32'h0000_B000, 32'h0102_0304, 32'h0,        3, 1'b0};

      rst = 1'b1;
      Load = 1'b0; Store = 1'b0; fun3 = '0; addr = '0; store_data = '0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
      check("rst_load_data", load_data, 32'h0);
      check("rst_load_valid", {31'h0, load_valid}, 32'h0);
      check("rst_misalign", {31'h0, misalign}, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      rst = 1'b0;

      // Reset while a store sits in REQ without a grant.
      @(negedge clk);
      Store = 1'b1; fun3 = 3'b010; addr = 32'h0000_3000; store_data = 32'h0000_0055;
      repeat (2) @(negedge clk);
      #1;
      check("midreq_req_before", {31'h0, bus.mem_req}, 32'h1);
      rst = 1'b1;
      #1;
      check("midreq_req_dropped", {31'h0, bus.mem_req}, 32'h0);
      check("midreq_wstrb_dropped", {28'h0, bus.mem_wstrb}, 32'h0);
      Store = 1'b0;
      #1;
      check("midreq_stall_idle", {31'h0, stall}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      #1;
      check("late_gnt_req", {31'h0, bus.mem_req}, 32'h0);
      check("late_gnt_load_valid", {31'h0, load_valid}, 32'h0);
      check("late_gnt_stall", {31'h0, stall}, 32'h0);
      check("late_gnt_load_data", load_data, 32'h0);
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side counterpart to the core's control decoder.
- Consumes the decoded Load/Store strobes, fun3, the ALU-computed address and the rs2 store data.
- Runs a request/grant/response transaction on the data-memory bus: byte-lane alignment, write strobes, load sign/zero extension.
- Stalls the single-cycle core until the access completes.

Parameters:
ADDR_WIDTH, 32, byte-address width on both core and memory sides.

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
Load  input  1  decoded load strobe
Store  input  1  decoded store strobe
fun3  input  3  instruction funct3, size/sign select
addr  input  ADDR_WIDTH  byte address from ALU
store_data  input  32  rs2 value
stall  output  1  hold PC/register-file write while high
load_data  output  32  extended load result
load_valid  output  1  load_data valid (one cycle)
misalign  output  1  misaligned-access flag (one cycle)
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  ADDR_WIDTH  word-aligned address (low 2 bits zero)
mem_wdata  output  32  lane-replicated write data
mem_wstrb  output  4  byte write enables
mem_gnt  input  1  request accepted
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word

Behaviour:
- Reset (async, immediate) values:
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, load_data, load_valid, misalign all 0.
  - A reset asserted mid-transaction drops mem_req in the same instant. Late mem_gnt/mem_rvalid after reset are ignored.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE:
    - Load|Store high: latch Load, fun3, addr, store_data; go to REQ.
    - Load and Store both high: Load wins, no write issued.
  - REQ:
    - mem_req = 1, held with addr/we/wdata/wstrb stable until mem_gnt.
    - On gnt: store goes to DONE.
    - On gnt for a load: goes to WAIT, or straight to DONE if mem_rvalid is high in the same cycle (zero-wait memory).
  - WAIT:
    - On mem_rvalid: capture extracted data into load_data, go to DONE.
    - Waits indefinitely otherwise.
  - DONE:
    - load_valid = 1 for loads, for exactly one cycle.
    - Returns to IDLE.
- stall (combinational):
  - 1 in IDLE when Load|Store.
  - 1 in REQ and WAIT.
  - 0 in DONE and in IDLE otherwise.
  - The core commits on the DONE clock edge. Minimum load/store latency is 2 stall cycles (IDLE, REQ) with zero-wait memory.
- mem_addr = {latched addr[ADDR_WIDTH-1:2], 2'b00}.
- Stores:
  - sb (000): wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
  - sh (001): wstrb = 0011 << {addr[1],0}; wdata = half replicated x2.
  - sw (010, and any other fun3): wstrb = 1111.
- Loads, lane selected by addr[1:0]:
  - lb (000): byte, sign-extended.
  - lh (001): half at addr[1], sign-extended.
  - lw (010, 110, and any other fun3): full word.
  - lbu (100): byte, zero-extended.
  - lhu (101): half, zero-extended.
- load_data holds its last value outside DONE.
- mem_we = 0 and wstrb = 0 for loads.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access goes IDLE->DONE directly with no bus request; misaligned stores perform no write.
  - In DONE: misalign = 1; for a load, load_data = 0 and load_valid = 1.
- Undefined:
  - misalign is tied 0.
  - Offending low address bits are ignored: halfword uses addr[1]; word is the aligned word.

Test Plan:
- Reset mid-REQ (mem_gnt held low, rst pulsed) -> mem_req 0 immediately, state IDLE, stall low once Load/Store drop.
- sb, addr=0x1003, store_data=0xA5, gnt after 2 cycles -> mem_addr 0x1000, wstrb 1000, wdata 0xA5A5A5A5, stall high 4 cycles.
- lb, addr=0x2002, mem_rdata=0x00800000, gnt and rvalid same cycle -> load_data 0xFFFFFF80, load_valid 1 cycle, total stall 2 cycles.
- lhu, addr=0x2002, rdata=0x8001FFFF, rvalid 3 cycles after gnt -> load_data 0x00008001 in DONE only.
- lw with Load and Store both high -> mem_we 0, wstrb 0000, normal load completes.
- MISALIGN_TRAP_EN defined, sw addr=0x3001 -> no mem_req, misalign 1 for one cycle, stall 1 cycle. Undefined -> write to 0x3000, wstrb 1111.
